maze_store: RTL and testbench
=============================

// Module: maze_store
// PURPOSE
//  Maze memory and responder for the solver's cell-access interface: holds a 2^maze_width square wall plane and a visited plane.
//  Answers maze_oe reads with the wall bit one cycle later and records maze_we marks in the visited plane.
//  A host loads the maze row by row, the solver runs, then the visited plane (solution trace) streams back out row by row.
// PARAMETERS
//  maze_width  6   coordinate width in bits; DIM = 1<<maze_width rows/cols (64x64 default)
// PORTS
//  clk           in   1      single clock, all logic on posedge
//  rst_n         in   1      synchronous reset, active-low
//  load_start    in   1      pulse in IDLE: begin a maze load
//  load_valid    in   1      host row beat valid
//  load_ready    out  1      store accepts a row beat
//  load_data     in   DIM    wall row, bit c = cell (row,c); 1 = wall
//  row, col      in   maze_width  cell selected by solver
//  maze_oe       in   1      solver read strobe (sync)
//  maze_we       in   1      solver mark strobe (sync)
//  maze_in       out  1      wall bit of the last read cell; 1 = wall
//  solver_done   in   1      solver found exit (level)
//  run_active    out  1      store is in RUN, solver accesses honoured
//  visit_count   out  maze_width*2+1  distinct cells marked this run
//  dump_valid    out  1      trace row beat valid
//  dump_ready    in   1      consumer accepts trace beat
//  dump_row      out  maze_width  index of row on dump_data
//  dump_data     out  DIM    visited row, bit c = cell (dump_row,c) marked
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, load_ready 0, maze_in 1, run_active 0, dump_valid 0, dump_row 0, dump_data 0, visit_count 0, row counters 0. Plane contents are not cleared by reset.
//  FSM: IDLE -> LOAD -> RUN -> DUMP -> IDLE; all outputs registered or decoded from registered state only.
//  IDLE: load_start -> LOAD; load_cnt=0, visit_count=0. Other inputs ignored.
//  LOAD: load_ready=1. Beat = load_valid&&load_ready at posedge: wall[load_cnt]<=load_data, visited[load_cnt]<=0, load_cnt++.
//   Beat with load_cnt==DIM-1 -> RUN next cycle (load_ready low in RUN). load_start ignored outside IDLE.
//  RUN: run_active=1.
//   maze_oe at edge N: maze_in = wall[row][col] from edge N until the next accepted read (1-cycle latency, holds otherwise).
//   maze_we at edge N: if visited[row][col]==0, set it and visit_count++; re-marking a cell does not count.
//   oe and we in same cycle: both performed; read returns wall bit (never altered by we).
//   solver_done sampled 1 -> DUMP; dump_cnt=0; accesses in that same cycle still performed.
//  Outside RUN: maze_oe/maze_we ignored, maze_in forced 1 (every cell reads as wall).
//  DUMP: dump_valid=1, dump_row=dump_cnt, dump_data=visited[dump_cnt]. Beat = dump_valid&&dump_ready.
//   dump_row/dump_data stable while dump_valid && !dump_ready. Beat at dump_cnt==DIM-1 -> IDLE, dump_valid 0.
//  Coordinates are maze_width bits, so every row/col is in range; no bounds check. Counters compare to DIM-1, never wrap.
//  visit_count saturates at DIM*DIM (cannot exceed; width maze_width*2+1).
//  Reset mid-operation: immediate return to IDLE with reset values; a partial load leaves old rows in the planes until reloaded.
// STRUCTURE
//  Package maze_pkg: state encoding (ST_IDLE, ST_LOAD, ST_RUN, ST_DUMP), MAZE_DIM derivation, WALL/FREE bit constants.
//  Sub-module maze_bitplane (DIM x DIM bits): row write, row read, single-bit read, single-bit set. Instantiated twice (wall, visited).
//  maze_store holds the FSM, load/dump counters, maze_in register, and visit counter.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> maze_in=1, load_ready=0, dump_valid=0, run_active=0, visit_count=0.
//  2 Load: 64 rows, border all walls except (0,5) free, interior free -> run_active=1 after 64th beat. oe at (1,1) -> maze_in=0 next cycle; (0,0) -> 1; (0,5) -> 0.
//  3 Marks: we at (3,3) twice, then (3,4), then oe+we same cycle at (3,5) -> visit_count=3; maze_in=0.
//  4 Gating: oe at (1,1) during IDLE/LOAD -> maze_in=1; load_valid while load_ready=0 -> no write (row 0 unchanged after reload check).
//  5 Dump: solver_done=1 -> 64 beats; hold dump_ready=0 for 3 cycles at row 3 -> data stable; row 3 = bits 3,4,5 set; then IDLE.
//  6 Reset mid-LOAD after 10 beats -> IDLE, load_ready=0; new load_start and full load -> RUN, visit_count=0.

Source files
------------

// File: rtl/maze_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maze_pkg : shared state encoding and plane constants for maze_store |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package maze_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  localparam logic WALL = 1'b1;
  localparam logic FREE = 1'b0;

  // Rows and columns per side for a given coordinate width.
  function automatic int maze_dim(input int width);
    return 1 << width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/maze_bitplane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maze_bitplane : square bit plane with row write/read and bit set/read|
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module maze_bitplane #(
  parameter int AW = 6
) (
  input  logic                  clk,
  input  logic                  i_row_we,
  input  logic [AW-1:0]         i_row_waddr,
  input  logic [(1<<AW)-1:0]    i_row_wdata,
  input  logic [AW-1:0]         i_rd_row,
  output logic [(1<<AW)-1:0]    o_rd_data,
  input  logic [AW-1:0]         i_bit_row,
  input  logic [AW-1:0]         i_bit_col,
  input  logic                  i_bit_set,
  output logic                  o_bit
);

  localparam int DIM = 1 << AW;

  logic [DIM-1:0] r_plane [DIM];

  // Contents are deliberately left unreset; a row write takes priority.
  always_ff @(posedge clk) begin
    if (i_row_we) begin
      r_plane[i_row_waddr] <= i_row_wdata;
    end else if (i_bit_set) begin
      r_plane[i_bit_row][i_bit_col] <= 1'b1;
    end
  end

  assign o_rd_data = r_plane[i_rd_row];
  assign o_bit     = r_plane[i_bit_row][i_bit_col];

endmodule
`default_nettype wire

// File: rtl/maze_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maze_store : maze wall/visited memory with load, solver and dump    |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module maze_store
  import maze_pkg::*;
#(
  parameter int maze_width = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_start,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [(1<<maze_width)-1:0]   load_data,
  input  logic [maze_width-1:0]        row,
  input  logic [maze_width-1:0]        col,
  input  logic                         maze_oe,
  input  logic                         maze_we,
  output logic                         maze_in,
  input  logic                         solver_done,
  output logic                         run_active,
  output logic [maze_width*2:0]        visit_count,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [maze_width-1:0]        dump_row,
  output logic [(1<<maze_width)-1:0]   dump_data
);

  localparam int DIM = maze_dim(maze_width);
  localparam int VW  = 2 * maze_width + 1;
  localparam logic [maze_width-1:0] c_LAST      = '1;
  localparam logic [VW-1:0]         c_VISIT_MAX = VW'(DIM * DIM);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [maze_width-1:0]  r_load_cnt;
  logic [maze_width-1:0]  r_dump_cnt;
  logic                   r_maze_in;
  logic [VW-1:0]          r_visit_count;

  logic                   w_run;
  logic                   w_load_beat;
  logic                   w_dump_beat;
  logic                   w_wall_bit;
  logic                   w_vis_bit;
  logic                   w_mark;
  logic [DIM-1:0]         w_vis_row;
  logic [DIM-1:0]         w_wall_row_unused;

  assign w_run       = (r_state == ST_RUN);
  assign w_load_beat = (r_state == ST_LOAD) && load_valid;
  assign w_dump_beat = (r_state == ST_DUMP) && dump_ready;
  assign w_mark      = w_run && maze_we && !w_vis_bit && (r_visit_count != c_VISIT_MAX);

  maze_bitplane #(.AW(maze_width)) u_wall (
    .clk         (clk),
    .i_row_we    (w_load_beat),
    .i_row_waddr (r_load_cnt),
    .i_row_wdata (load_data),
    .i_rd_row    (r_load_cnt),
    .o_rd_data   (w_wall_row_unused),
    .i_bit_row   (row),
    .i_bit_col   (col),
    .i_bit_set   (1'b0),
    .o_bit       (w_wall_bit)
  );

  // Loading a row also wipes that row's trace from any previous run.
  maze_bitplane #(.AW(maze_width)) u_visited (
    .clk         (clk),
    .i_row_we    (w_load_beat),
    .i_row_waddr (r_load_cnt),
    .i_row_wdata ('0),
    .i_rd_row    (r_dump_cnt),
    .o_rd_data   (w_vis_row),
    .i_bit_row   (row),
    .i_bit_col   (col),
    .i_bit_set   (w_run && maze_we),
    .o_bit       (w_vis_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (load_start) w_state_nxt = ST_LOAD;
      ST_LOAD: if (w_load_beat && r_load_cnt == c_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  if (solver_done) w_state_nxt = ST_DUMP;
      ST_DUMP: if (w_dump_beat && r_dump_cnt == c_LAST) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_cnt    <= '0;
      r_dump_cnt    <= '0;
      r_maze_in     <= WALL;
      r_visit_count <= '0;
    end else begin
      if ((r_state == ST_IDLE) && load_start) begin
        r_load_cnt    <= '0;
        r_visit_count <= '0;
      end
      if (w_load_beat && (r_load_cnt != c_LAST)) begin
        r_load_cnt <= r_load_cnt + 1'b1;
      end
      if (w_run && solver_done) begin
        r_dump_cnt <= '0;
      end
      if (w_dump_beat && (r_dump_cnt != c_LAST)) begin
        r_dump_cnt <= r_dump_cnt + 1'b1;
      end
      if (!w_run) begin
        r_maze_in <= WALL;
      end else if (maze_oe) begin
        r_maze_in <= w_wall_bit;
      end
      if (w_mark) begin
        r_visit_count <= r_visit_count + 1'b1;
      end
    end
  end

  assign load_ready  = (r_state == ST_LOAD);
  assign run_active  = w_run;
  assign dump_valid  = (r_state == ST_DUMP);
  assign maze_in     = w_run ? r_maze_in : WALL;
  assign visit_count = r_visit_count;
  assign dump_row    = r_dump_cnt;
  assign dump_data   = dump_valid ? w_vis_row : '0;

endmodule
`default_nettype wire

// File: tb/tb_maze_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_maze_store : randomized bench with a behavioural maze model      |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_maze_store;

  localparam int MW  = 6;
  localparam int DIM = 1 << MW;
  localparam int VW  = 2 * MW + 1;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DUMP = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_start = 1'b0, load_valid = 1'b0;
  logic [DIM-1:0]  load_data = '0;
  logic [MW-1:0]   row = '0, col = '0;
  logic            maze_oe = 1'b0, maze_we = 1'b0, solver_done = 1'b0, dump_ready = 1'b0;
  logic            load_ready, maze_in, run_active, dump_valid;
  logic [VW-1:0]   visit_count;
  logic [MW-1:0]   dump_row;
  logic [DIM-1:0]  dump_data;

  always #5 clk = ~clk;

  maze_store #(.maze_width(MW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .solver_done(solver_done), .run_active(run_active), .visit_count(visit_count),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_row(dump_row),
    .dump_data(dump_data)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Behavioural model: phase, cursors, planes and counters.
  int             ph = P_IDLE;
  int             m_lc = 0, m_dc = 0, m_vc = 0;
  bit             m_rdv = 1'b0;
  logic           m_rd = 1'b1;
  logic [DIM-1:0] m_wall [DIM];
  logic [DIM-1:0] m_vis  [DIM];

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = P_IDLE; m_lc = 0; m_dc = 0; m_vc = 0; m_rdv = 1'b0;
    end else begin
      case (ph)
        P_IDLE: if (load_start) begin ph = P_LOAD; m_lc = 0; m_vc = 0; end
        P_LOAD: if (load_valid) begin
          m_wall[m_lc] = load_data;
          m_vis[m_lc]  = '0;
          if (m_lc == DIM - 1) begin ph = P_RUN; m_rdv = 1'b0; end
          else m_lc++;
        end
        P_RUN: begin
          if (maze_oe) begin m_rd = m_wall[row][col]; m_rdv = 1'b1; end
          if (maze_we && !m_vis[row][col]) begin
            m_vis[row][col] = 1'b1;
            if (m_vc < DIM * DIM) m_vc++;
          end
          if (solver_done) begin ph = P_DUMP; m_dc = 0; end
        end
        default: if (dump_ready) begin
          if (m_dc == DIM - 1) ph = P_IDLE;
          else m_dc++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("load_ready", load_ready, ph == P_LOAD);
      chk("run_active", run_active, ph == P_RUN);
      chk("dump_valid", dump_valid, ph == P_DUMP);
      chk("visit_count", visit_count, m_vc);
      if (ph != P_RUN) chk("maze_in_gated", maze_in, 1);
      else if (m_rdv) chk("maze_in", maze_in, m_rd);
      if (ph == P_DUMP) begin
        chk("dump_row", dump_row, m_dc);
        chk("dump_data", dump_data, m_vis[m_dc]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DIM-1:0] make_row(input int r, input int mode);
    logic [DIM-1:0] v;
    if (mode != 0) begin
      v = {$urandom, $urandom};
    end else if (r == 0) begin
      v = '1;
      v[5] = 1'b0;
    end else if (r == DIM - 1) begin
      v = '1;
    end else begin
      v = '0;
      v[0] = 1'b1;
      v[DIM-1] = 1'b1;
    end
    return v;
  endfunction

  task automatic load_maze(input int mode, input bit gaps, input int nbeats);
    int beats = 0;
    int guard = 0;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    while (beats < nbeats && guard < 1000) begin
      load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data  = make_row(beats, mode);
      if (load_valid && load_ready) beats++;
      cyc();
      guard++;
    end
    load_valid = 1'b0;
    if (guard >= 1000) timeout("load_timeout");
  endtask

  task automatic access(input int r, input int c, input bit oe, input bit we);
    row = MW'(r); col = MW'(c); maze_oe = oe; maze_we = we;
    cyc();
    maze_oe = 1'b0; maze_we = 1'b0;
  endtask

  task automatic dump_all(input bit rnd, input bit stall3);
    int guard = 0;
    bit stalled = 1'b0;
    solver_done = 1'b1;
    cyc();
    solver_done = 1'b0;
    chk("dump_enter", dump_valid, 1);
    while (dump_valid && guard < 2000) begin
      if (stall3 && !stalled && dump_row == 3) begin
        dump_ready = 1'b0;
        repeat (3) begin
          cyc();
          chk("dump_hold_row", dump_row, 3);
          chk("dump_hold_data", dump_data, 64'h38);
        end
        stalled = 1'b1;
      end
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      guard++;
    end
    dump_ready = 1'b0;
    if (guard >= 2000) timeout("dump_timeout");
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    #2;
    cyc();
    chk("rst_maze_in", maze_in, 1);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_run_active", run_active, 0);
    chk("rst_visit_count", visit_count, 0);
    rst_n = 1'b1;

    // Ignored traffic while idle
    load_valid = 1'b1;
    access(1, 1, 1'b1, 1'b1);
    load_valid = 1'b0;
    chk("idle_read", maze_in, 1);

    // Bordered maze; reads held on (1,1) through the load must be ignored
    row = 1; col = 1; maze_oe = 1'b1;
    load_maze(0, 1'b0, DIM);
    maze_oe = 1'b0;
    chk("run_after_load", run_active, 1);
    access(1, 1, 1'b1, 1'b0); chk("rd_1_1", maze_in, 0);
    access(0, 0, 1'b1, 1'b0); chk("rd_0_0", maze_in, 1);
    access(0, 5, 1'b1, 1'b0); chk("rd_0_5", maze_in, 0);
    access(2, 2, 1'b0, 1'b0); chk("rd_hold", maze_in, 0);

    // Row beats offered outside LOAD must not write
    load_valid = 1'b1; load_data = '0;
    repeat (3) cyc();
    load_valid = 1'b0;
    access(0, 0, 1'b1, 1'b0); chk("no_stray_write", maze_in, 1);

    access(3, 3, 1'b0, 1'b1);
    access(3, 3, 1'b0, 1'b1);
    access(3, 4, 1'b0, 1'b1);
    access(3, 5, 1'b1, 1'b1);
    chk("marks_count", visit_count, 3);
    chk("marks_read", maze_in, 0);

    dump_all(1'b0, 1'b1);
    chk("idle_after_dump", load_ready | run_active | dump_valid, 0);

    // Reset in the middle of a load, then a full random reload
    load_maze(1, 1'b0, 10);
    rst_n = 1'b0;
    cyc();
    chk("midload_rst_ready", load_ready, 0);
    rst_n = 1'b1;
    load_maze(1, 1'b1, DIM);
    chk("reload_run", run_active, 1);
    chk("reload_vc", visit_count, 0);

    // Random solver traffic concentrated in a corner to force re-marks
    for (int i = 0; i < 500; i++) begin
      access($urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    dump_all(1'b1, 1'b0);

    // Mark every cell, then keep marking: count must stop at DIM*DIM
    load_maze(1, 1'b1, DIM);
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        access(r, c, 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    for (int i = 0; i < 20; i++) begin
      access($urandom_range(0, DIM - 1), $urandom_range(0, DIM - 1), 1'b1, 1'b1);
    end
    chk("saturated_vc", visit_count, DIM * DIM);
    dump_all(1'b1, 1'b0);

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
